// File: rtl/regfile_reader.sv
// Streams the sort register file out in index order on a valid/ready port.
// Define REGFILE_READER_SNAPSHOT_EN to stream from a copy taken at start.
module regfile_reader #(
    parameter int WIDTH = 8,
    parameter int COUNT = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] ReadBus0,
    input  logic [WIDTH-1:0] ReadBus1,
    input  logic [WIDTH-1:0] ReadBus2,
    input  logic [WIDTH-1:0] ReadBus3,
    input  logic [WIDTH-1:0] ReadBus4,
    input  logic [WIDTH-1:0] ReadBus5,
    input  logic [WIDTH-1:0] ReadBus6,
    input  logic [WIDTH-1:0] ReadBus7,
    input  logic [WIDTH-1:0] ReadBus8,
    input  logic [WIDTH-1:0] ReadBus9,
    input  logic [WIDTH-1:0] ReadBus10,
    input  logic [WIDTH-1:0] ReadBus11,
    input  logic [WIDTH-1:0] ReadBus12,
    input  logic [WIDTH-1:0] ReadBus13,
    input  logic [WIDTH-1:0] ReadBus14,
    input  logic [WIDTH-1:0] ReadBus15,
    input  logic [WIDTH-1:0] ReadBus16,
    input  logic [WIDTH-1:0] ReadBus17,
    input  logic [WIDTH-1:0] ReadBus18,
    input  logic [WIDTH-1:0] ReadBus19,
    input  logic [WIDTH-1:0] ReadBus20,
    input  logic [WIDTH-1:0] ReadBus21,
    input  logic [WIDTH-1:0] ReadBus22,
    input  logic [WIDTH-1:0] ReadBus23,
    input  logic [WIDTH-1:0] ReadBus24,
    input  logic [WIDTH-1:0] ReadBus25,
    input  logic [WIDTH-1:0] ReadBus26,
    input  logic [WIDTH-1:0] ReadBus27,
    input  logic [WIDTH-1:0] ReadBus28,
    input  logic [WIDTH-1:0] ReadBus29,
    input  logic [WIDTH-1:0] ReadBus30,
    input  logic [WIDTH-1:0] ReadBus31,
    output logic [WIDTH-1:0] out_data,
    output logic [4:0]       out_index,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH+4:0] out_sum
);

    typedef enum logic [1:0] {
        Idle,
        Stream,
        Done
    } stateT;

    localparam logic [4:0] LAST = 5'(COUNT - 1);

    stateT            state, stateNext;
    logic [4:0]       counter, counterNext;
    logic [WIDTH-1:0] dataReg, dataNext;
    logic [WIDTH+4:0] sumReg, sumNext;
    logic [4:0]       counterInc;
    logic [WIDTH-1:0] bus [32];
    logic [WIDTH-1:0] src [32];

    assign bus = '{
        ReadBus0,  ReadBus1,  ReadBus2,  ReadBus3,
        ReadBus4,  ReadBus5,  ReadBus6,  ReadBus7,
        ReadBus8,  ReadBus9,  ReadBus10, ReadBus11,
        ReadBus12, ReadBus13, ReadBus14, ReadBus15,
        ReadBus16, ReadBus17, ReadBus18, ReadBus19,
        ReadBus20, ReadBus21, ReadBus22, ReadBus23,
        ReadBus24, ReadBus25, ReadBus26, ReadBus27,
        ReadBus28, ReadBus29, ReadBus30, ReadBus31
    };

`ifdef REGFILE_READER_SNAPSHOT_EN
    logic [WIDTH-1:0] snap [32];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) snap[i] <= '0;
        end else if (state == Idle && start) begin
            snap <= bus;
        end
    end

    assign src = snap;
`else
    assign src = bus;
`endif

    assign counterInc = counter + 5'd1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= Idle;
            counter <= '0;
            dataReg <= '0;
            sumReg  <= '0;
        end else begin
            state   <= stateNext;
            counter <= counterNext;
            dataReg <= dataNext;
            sumReg  <= sumNext;
        end
    end

    always_comb begin
        stateNext   = state;
        counterNext = counter;
        dataNext    = dataReg;
        sumNext     = sumReg;
        unique case (state)
            Idle: begin
                counterNext = '0;
                if (start) begin
                    stateNext = Stream;
                    sumNext   = '0;
                    // Entry 0 comes straight off the bus at the start edge.
                    dataNext  = bus[0];
                end
            end
            Stream: begin
                if (out_ready) begin
                    sumNext = sumReg + {5'd0, dataReg};
                    if (counter == LAST) begin
                        stateNext = Done;
                    end else begin
                        counterNext = counterInc;
                        dataNext    = src[counterInc];
                    end
                end
            end
            Done: stateNext = Idle;
            default: stateNext = Idle;
        endcase
    end

    assign out_data  = dataReg;
    assign out_index = counter;
    assign out_sum   = sumReg;
    assign out_valid = (state == Stream);
    assign busy      = (state != Idle);
    assign done      = (state == Done);

endmodule
